uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive engine for the APB UART peripheral. It sits between the `rxd` pin and the UART's APB register/interrupt logic. It synchronises and oversamples the line at 16x and de-frames 8-bit characters (8N1, optional parity). Each byte is handed downstream through a one-entry valid/ready holding register, together with per-character error flags.

## Interface
Parameters:
- `DIV_W`, 16: width of the baud divisor input.

Ports:
- `pclk` in 1: system clock, single clock domain.
- `presetn` in 1: asynchronous, active-low reset.
- `rxd` in 1: asynchronous serial input, idle high.
- `baud_div` in DIV_W: the oversample tick fires every `baud_div+1` pclk cycles. Change only while idle.
- `parity_en` in 1: 1 = a parity bit follows the data bits.
- `parity_odd` in 1: 1 = odd parity, 0 = even parity.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` and its flags are valid.
- `rx_ready` in 1: downstream accepts the byte.
- `frame_err` out 1: stop bit sampled 0; valid with `rx_data`.
- `parity_err` out 1: parity mismatch; valid with `rx_data`.
- `overrun` out 1: one-cycle pulse when a byte is dropped.

## Operation
- **Synchroniser.** `rxd` passes through 2 flops, both reset to 1. All logic uses the synchronised value `rxs`. Falling-edge detect compares `rxs` with its delayed copy.
- **Tick generator.** A down-counter reloads with `baud_div` and emits a 1-cycle `tick` at 0.
  - It is forced to reload on start-edge detect, so bit timing is phase-aligned to the edge.
  - `baud_div=0` gives a tick every cycle.
- **Oversample counter.** `os_cnt` is 4 bits and increments per tick; it wraps 15→0 at each bit boundary. Samples are taken at `os_cnt` 7, 8 and 9. The bit value is the 2-of-3 majority.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** on a falling edge of `rxs`, clear `os_cnt` and the bit counter, then go to START.
  - **START:** on the tick at `os_cnt=9`:
    - majority 0 → go to DATA and clear `os_cnt` at the boundary;
    - majority 1 → glitch; go to IDLE and deliver nothing.
  - **DATA:** 8 bits, LSB first, shifted in on each `os_cnt=9` vote. After bit 7, go to PARITY if `parity_en`, else STOP.
  - **PARITY:** compute `parity_err` = (XOR of the data bits XOR the parity bit XOR `parity_odd`) != 0. Then go to STOP.
  - **STOP:** on the `os_cnt=9` vote, set `frame_err` = !vote, deliver the byte and go to IDLE. The remaining half of the stop bit is not waited out.
- **Break / stuck-low line.** After a frame error IDLE needs a fresh falling edge, so a stuck-low line produces exactly one frame error.
- **Delivery:**
  - If `rx_valid`=0, or `rx_valid&&rx_ready` in the same cycle: load `rx_data`, `frame_err` and `parity_err`, and assert `rx_valid`.
  - Otherwise: keep the held byte and its flags, drop the new byte, and pulse `overrun`.
- **Handshake.** A transfer occurs on `rx_valid&&rx_ready`. `rx_valid` then falls the next cycle unless a new byte is delivered in the same cycle.
- **Flag clearing.** `parity_err` and `frame_err` are cleared only when a new byte loads.
- **Reset mid-frame.** Reset returns to IDLE, discards any partial byte, and clears the holding register.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0;
  - FSM in IDLE, synchroniser flops at 1.
- Edge detect lags the pin by 2–3 pclk cycles, which is synchroniser latency.
- Bit period is 16×(`baud_div`+1) pclk cycles.
- Latency from the start-bit edge at `rxs` to `rx_valid` rising: (9+16×9)×(`baud_div`+1)+1 cycles without parity. Add 16×(`baud_div`+1) cycles with parity.
- `rx_valid` rises the cycle after the stop-vote tick.
- `overrun` is high for exactly that same cycle.
- `rx_ready` may be high before `rx_valid`; there is no combinational path from `rx_ready` to `rx_valid`.

## Structure
- Shared package `uart_pkg`, which the future TX core will also use:
  - `rx_state_t` enum;
  - `OVERSAMPLE`=16;
  - `SAMPLE_LO`=7, `SAMPLE_MID`=8, `SAMPLE_HI`=9.
- Sub-module `uart_baud_tick`: divisor counter with a sync-reload input and a `tick` output, reused by the TX side.
- The synchroniser, FSM, shifter and holding register stay in `uart_rx_core`.

## Test plan
- **Basic receive.** `baud_div`=0, no parity, send 0xA5 → `rx_valid` high with `rx_data`=0xA5, `frame_err`=0, `parity_err`=0, at edge+154±3 cycles.
- **Parity.** `parity_en`=1, `parity_odd`=0, send 0x07 with parity bit 0 → `parity_err`=1. The same byte with parity bit 1 → `parity_err`=0.
- **Start glitch.** A 4-cycle low pulse at `baud_div`=0 → no `rx_valid` and FSM back in IDLE. A following 0x3C is received correctly.
- **Framing and break:**
  - stop bit forced 0 → `frame_err`=1 with the data byte;
  - line held low for 40 bit times → exactly one `rx_valid`, with `rx_data`=0x00 and `frame_err`=1.
- **Overrun.** `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun` pulses 1 cycle at the second stop vote. Asserting `rx_ready` then drops `rx_valid`.
- **Reset mid-frame.** Assert `presetn`=0 during DATA bit 4 → all outputs 0 and FSM in IDLE. The next full frame 0x5A is received correctly; at `baud_div`=3, the bit period is 64 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (oversampling, sample points, RX FSM).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int OS_W       = $clog2(OVERSAMPLE);

  typedef logic [OS_W-1:0] os_cnt_t;

  localparam os_cnt_t SAMPLE_LO  = os_cnt_t'(7);
  localparam os_cnt_t SAMPLE_MID = os_cnt_t'(8);
  localparam os_cnt_t SAMPLE_HI  = os_cnt_t'(9);

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Oversample tick generator; reloadable down-counter on baud_div.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             reload,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
    end else if (reload || (r_cnt == '0)) begin
      r_cnt <= baud_div;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module      : uart_rx_core
// Description : 16x oversampling 8N1 (+optional parity) receiver with a
//               one-entry valid/ready holding register and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_core #(
  parameter int DIV_W = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             rxd,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  import uart_pkg::*;

  logic      r_sync1, r_rxs, r_rxs_d;
  logic      w_fall, w_tick, w_active, w_vote_tick, w_vote;
  logic      w_start, w_shift, w_par_chk, w_deliver;
  rx_state_t r_state, w_state_nxt;
  os_cnt_t   r_os_cnt, w_os_nxt;
  logic [2:0] r_bit_cnt;
  logic      r_s_lo, r_s_mid;
  logic [7:0] r_shift;
  logic      r_par_pend;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  assign w_fall = r_rxs_d & ~r_rxs;

  // Reload on the start edge so every sample point is phase-locked to it.
  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .pclk     (pclk),
    .presetn  (presetn),
    .baud_div (baud_div),
    .reload   (w_start),
    .tick     (w_tick)
  );

  assign w_active    = (r_state != RX_IDLE);
  assign w_os_nxt    = r_os_cnt + os_cnt_t'(1);
  assign w_vote_tick = w_tick & w_active & (w_os_nxt == SAMPLE_HI);
  assign w_vote      = maj3(r_s_lo, r_s_mid, r_rxs);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:   if (w_fall) w_state_nxt = RX_START;
      RX_START:  if (w_vote_tick) w_state_nxt = w_vote ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_vote_tick && (r_bit_cnt == 3'd7))
                   w_state_nxt = parity_en ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_vote_tick) w_state_nxt = RX_STOP;
      RX_STOP:   if (w_vote_tick) w_state_nxt = RX_IDLE;
      default:   w_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_start   = 1'b0;
    w_shift   = 1'b0;
    w_par_chk = 1'b0;
    w_deliver = 1'b0;
    case (r_state)
      RX_IDLE:   w_start   = w_fall;
      RX_DATA:   w_shift   = w_vote_tick;
      RX_PARITY: w_par_chk = w_vote_tick;
      RX_STOP:   w_deliver = w_vote_tick;
      default:   ;
    endcase
  end

  // os_cnt holds the tick count within the bit; the vote lands on the 9th.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_s_lo     <= 1'b1;
      r_s_mid    <= 1'b1;
      r_shift    <= '0;
      r_par_pend <= 1'b0;
    end else begin
      if (w_start) begin
        r_os_cnt   <= '0;
        r_bit_cnt  <= '0;
        r_par_pend <= 1'b0;
      end else if (w_tick && w_active) begin
        r_os_cnt <= w_os_nxt;
      end
      if (w_tick && w_active && (w_os_nxt == SAMPLE_LO)) r_s_lo  <= r_rxs;
      if (w_tick && w_active && (w_os_nxt == SAMPLE_MID)) r_s_mid <= r_rxs;
      if (w_shift) begin
        r_shift   <= {w_vote, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_chk) r_par_pend <= (^r_shift) ^ w_vote ^ parity_odd;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_deliver && (!rx_valid || rx_ready)) begin
        rx_data    <= r_shift;
        frame_err  <= ~w_vote;
        parity_err <= r_par_pend;
        rx_valid   <= 1'b1;
      end else begin
        if (w_deliver) overrun <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Scoreboard bench for uart_rx_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

  import uart_pkg::*;

  localparam int DIV_W = 16;

  logic             pclk = 1'b0;
  logic             presetn;
  logic             rxd;
  logic [DIV_W-1:0] baud_div;
  logic             parity_en;
  logic             parity_odd;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   t_start  = 0;
  int   t_rise   = 0;
  int   n_rise   = 0;
  int   n_ovr    = 0;
  logic r_prev_valid = 1'b0;

  uart_rx_core #(.DIV_W(DIV_W)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .rxd        (rxd),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 2 time units after the rising edge; observation is on the falling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d;
    e.ferr = fe;
    e.perr = pe;
    q_exp.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb_en, input logic pb,
                            input logic stop, input int div);
    int bp;
    bp = 16 * (div + 1);
    rxd     = 1'b0;
    t_start = cyc;
    wait_cyc(bp);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_cyc(bp);
    end
    if (pb_en) begin
      rxd = pb;
      wait_cyc(bp);
    end
    rxd = stop;
    wait_cyc(bp);
    rxd = 1'b1;
    wait_cyc(2 * bp);
  endtask

  // Scoreboard side: a transfer happens at the next rising edge when valid && ready.
  always @(negedge pclk) begin
    exp_t e;
    if (rx_valid && !r_prev_valid) begin
      n_rise++;
      t_rise = cyc;
    end
    r_prev_valid = rx_valid;
    if (overrun) n_ovr++;
    if (presetn && rx_valid && rx_ready) begin
      if (q_exp.size() == 0) begin
        check("unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        e = q_exp.pop_front();
        check("rx_data",    32'(rx_data),    32'(e.data));
        check("frame_err",  32'(frame_err),  32'(e.ferr));
        check("parity_err", 32'(parity_err), 32'(e.perr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rises0;
    int ovr0;
    presetn    = 1'b0;
    rxd        = 1'b1;
    baud_div   = '0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    rx_ready   = 1'b1;
    wait_cyc(4);
    @(negedge pclk);
    check("rst_rx_data",    32'(rx_data),    32'h0);
    check("rst_rx_valid",   32'(rx_valid),   32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    check("rst_state",      32'(dut.r_state), 32'(RX_IDLE));
    wait_cyc(1);
    presetn = 1'b1;
    wait_cyc(8);

    // Basic receive and start-edge-to-valid latency at baud_div=0.
    expect_byte(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0);
    lat = t_rise - t_start;
    check("latency_div0", 32'((lat >= 151) && (lat <= 157)), 32'h1);

    // Parity: 0x07 has three ones.
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    expect_byte(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0);
    expect_byte(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0);
    parity_odd = 1'b1;
    expect_byte(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0);
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    wait_cyc(4);

    // Start glitch is rejected, next frame still received.
    rises0 = n_rise;
    rxd = 1'b0;
    wait_cyc(4);
    rxd = 1'b1;
    wait_cyc(40);
    @(negedge pclk);
    check("glitch_no_valid", 32'(n_rise - rises0), 32'h0);
    check("glitch_idle",     32'(dut.r_state),     32'(RX_IDLE));
    wait_cyc(1);
    expect_byte(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 0);

    // Framing error, then a 40-bit-time break.
    expect_byte(8'h96, 1'b1, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 0);
    rises0 = n_rise;
    expect_byte(8'h00, 1'b1, 1'b0);
    rxd = 1'b0;
    wait_cyc(40 * 16);
    rxd = 1'b1;
    wait_cyc(64);
    check("break_one_valid", 32'(n_rise - rises0), 32'h1);

    // Overrun: second byte dropped while the first is held.
    rx_ready = 1'b0;
    ovr0 = n_ovr;
    expect_byte(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0);
    check("ovr_none_yet", 32'(n_ovr - ovr0), 32'h0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0);
    @(negedge pclk);
    check("ovr_pulse_cycles", 32'(n_ovr - ovr0), 32'h1);
    check("ovr_held_valid",   32'(rx_valid),     32'h1);
    check("ovr_held_data",    32'(rx_data),      32'h11);
    wait_cyc(1);
    rx_ready = 1'b1;
    wait_cyc(1);
    @(negedge pclk);
    check("ovr_valid_drops",  32'(rx_valid),     32'h0);
    wait_cyc(1);

    // Reset during DATA bit 4 at baud_div=3 with a byte held.
    baud_div = DIV_W'(3);
    rx_ready = 1'b0;
    wait_cyc(8);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 3);
    @(negedge pclk);
    check("hold_valid", 32'(rx_valid), 32'h1);
    check("hold_data",  32'(rx_data),  32'h81);
    wait_cyc(1);
    rxd = 1'b0;
    wait_cyc(64);
    for (int i = 0; i < 4; i++) begin
      rxd = (i[0] == 1'b1);
      wait_cyc(64);
    end
    rxd = 1'b1;
    wait_cyc(32);
    check("mid_state_data", 32'(dut.r_state), 32'(RX_DATA));
    presetn = 1'b0;
    wait_cyc(2);
    @(negedge pclk);
    check("mrst_rx_data",    32'(rx_data),      32'h0);
    check("mrst_rx_valid",   32'(rx_valid),     32'h0);
    check("mrst_frame_err",  32'(frame_err),    32'h0);
    check("mrst_parity_err", 32'(parity_err),   32'h0);
    check("mrst_overrun",    32'(overrun),      32'h0);
    check("mrst_state",      32'(dut.r_state),  32'(RX_IDLE));
    wait_cyc(1);
    presetn  = 1'b1;
    rx_ready = 1'b1;
    wait_cyc(128);
    expect_byte(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 3);
    lat = t_rise - t_start;
    check("latency_div3", 32'((lat >= 613) && (lat <= 619)), 32'h1);

    wait_cyc(16);
    check("scoreboard_empty", 32'(q_exp.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
